seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 87 ++++++++
 tb/tb_seq_detect_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Emits a registered one-cycle pulse per match and keeps a saturating match count.
module seq_detect_param #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = 5,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0001_0110),
  parameter int unsigned        DEF_LEN     = 5,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_in,
  input  logic               valid_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               data_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;
  logic               cfg_ok;

  always_comb begin
    hist_shift = {hist[MAX_LEN-2:0], data_in};
    fill_inc   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    // Only the low L bits of pattern and history take part in the compare.
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match  = valid_in && !cfg_load && (fill_inc >= len) &&
             (((hist_shift ^ pattern) & mask) == '0);
    cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern     <= DEF_PATTERN;
      len         <= LEN_W'(DEF_LEN);
      overlap     <= DEF_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      data_out    <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      data_out <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_load) begin
        if (cfg_ok) begin
          pattern     <= cfg_pattern;
          len         <= cfg_len;
          overlap     <= cfg_overlap;
          hist        <= '0;
          fill        <= '0;
          match_count <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (valid_in) begin
        hist <= hist_shift;
        // Non-overlapping mode restarts the fill so the next match needs L fresh bits.
        fill <= (match && !overlap) ? '0 : fill_inc;
        if (match) begin
          data_out <= 1'b1;
          if (match_count != '1) begin
            match_count <= match_count + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param: default instance plus a
// narrow-counter instance for saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, data_in, valid_in, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [4:0] cfg_len;
  logic       data_out, cfg_err;
  logic [7:0] match_count;

  logic       b_rst, b_data_in, b_valid_in, b_cfg_load, b_cfg_overlap;
  logic [7:0] b_cfg_pattern;
  logic [4:0] b_cfg_len;
  logic       b_data_out, b_cfg_err;
  logic [1:0] b_match_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .data_out(data_out),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .data_in(b_data_in), .valid_in(b_valid_in),
    .cfg_load(b_cfg_load), .cfg_pattern(b_cfg_pattern), .cfg_len(b_cfg_len),
    .cfg_overlap(b_cfg_overlap), .data_out(b_data_out),
    .match_count(b_match_count), .cfg_err(b_cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic d, input logic v);
    data_in  = d;
    valid_in = v;
    cyc();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [4:0] len, input logic ov, input logic d);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    tick(d, 1'b1);
    cfg_load = 1'b0;
  endtask

  initial begin
    logic [7:0] bits8;
    logic [7:0] exp8;
    logic [5:0] bits6;
    logic [5:0] exp6;
    logic [3:0] bits4;
    logic [3:0] exp4;

    rst = 1'b0; data_in = 1'b0; valid_in = 1'b0; cfg_load = 1'b0;
    cfg_overlap = 1'b0; cfg_pattern = '0; cfg_len = '0;
    b_rst = 1'b1; b_data_in = 1'b0; b_valid_in = 1'b0; b_cfg_load = 1'b0;
    b_cfg_overlap = 1'b0; b_cfg_pattern = '0; b_cfg_len = '0;

    // Reset state
    do_rst();
    b_rst = 1'b0;
    check("rst_data_out", data_out, 0);
    check("rst_count", match_count, 0);
    check("rst_cfg_err", cfg_err, 0);

    // Defaults, overlapping: 10110110
    bits8 = 8'b1011_0110;
    exp8  = 8'b0000_1001;
    for (int i = 0; i < 8; i++) begin
      tick(bits8[7-i], 1'b1);
      check($sformatf("ovl_bit%0d", i + 1), data_out, exp8[7-i]);
    end
    check("ovl_count", match_count, 2);
    tick(1'b0, 1'b0);
    check("ovl_idle", data_out, 0);

    // Load 10110, non-overlapping; data_in=1 on the load edge must be ignored
    cfg(8'b0001_0110, 5'd5, 1'b0, 1'b1);
    check("load_data_out", data_out, 0);
    check("load_count_clr", match_count, 0);
    check("load_cfg_err", cfg_err, 0);
    exp8 = 8'b0000_1000;
    for (int i = 0; i < 8; i++) begin
      tick(bits8[7-i], 1'b1);
      check($sformatf("novl_bit%0d", i + 1), data_out, exp8[7-i]);
    end
    check("novl_count", match_count, 1);

    // Gaps of valid_in=0 are transparent
    do_rst();
    bits8 = 8'b0001_0110;
    for (int i = 0; i < 5; i++) begin
      tick(bits8[4-i], 1'b1);
      check($sformatf("gap_bit%0d", i + 1), data_out, (i == 4) ? 1 : 0);
      if (i < 4) begin
        for (int g = 0; g < 3; g++) begin
          tick(1'b1, 1'b0);
          check("gap_idle", data_out, 0);
        end
      end
    end
    tick(1'b0, 1'b0);
    check("gap_after", data_out, 0);
    check("gap_count", match_count, 1);

    // Reset mid-sequence discards progress
    do_rst();
    tick(1'b1, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
    do_rst();
    check("midrst_data_out", data_out, 0);
    tick(1'b0, 1'b1);
    check("midrst_last", data_out, 0);
    check("midrst_count", match_count, 0);

    // Rejected loads leave configuration, history and count untouched
    do_rst();
    for (int i = 0; i < 5; i++) begin
      tick(bits8[4-i], 1'b1);
    end
    check("err_pre_pulse", data_out, 1);
    check("err_pre_count", match_count, 1);
    tick(1'b1, 1'b1);
    check("err_b6", data_out, 0);
    cfg(8'hFF, 5'd0, 1'b0, 1'b0);
    check("err_len0_pulse", cfg_err, 1);
    check("err_len0_dout", data_out, 0);
    check("err_len0_count", match_count, 1);
    tick(1'b1, 1'b1);
    check("err_len0_clear", cfg_err, 0);
    check("err_b7", data_out, 0);
    cfg(8'hFF, 5'd9, 1'b0, 1'b0);
    check("err_len9_pulse", cfg_err, 1);
    tick(1'b0, 1'b1);
    check("err_len9_clear", cfg_err, 0);
    check("err_b8_match", data_out, 1);
    check("err_count", match_count, 2);

    // L=1, non-overlapping, pattern bit 0
    cfg(8'h00, 5'd1, 1'b0, 1'b0);
    bits4 = 4'b0010;
    exp4  = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      tick(bits4[3-i], 1'b1);
      check($sformatf("l1_bit%0d", i + 1), data_out, exp4[3-i]);
    end
    check("l1_count", match_count, 3);

    // Pattern bits above L-1 are ignored (F6 with L=3 means 110)
    cfg(8'hF6, 5'd3, 1'b1, 1'b0);
    bits6 = 6'b110110;
    exp6  = 6'b001001;
    for (int i = 0; i < 6; i++) begin
      tick(bits6[5-i], 1'b1);
      check($sformatf("hi_bit%0d", i + 1), data_out, exp6[5-i]);
    end
    check("hi_count", match_count, 2);

    // Narrow counter saturates at 3
    b_cfg_load = 1'b1; b_cfg_pattern = 8'h01; b_cfg_len = 5'd1; b_cfg_overlap = 1'b1;
    b_valid_in = 1'b1; b_data_in = 1'b1;
    cyc();
    b_cfg_load = 1'b0;
    check("sat_load_count", b_match_count, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("sat_pulse%0d", i + 1), b_data_out, 1);
      check($sformatf("sat_count%0d", i + 1), b_match_count, (i < 3) ? i + 1 : 3);
    end
    b_valid_in = 1'b0;
    cyc();
    check("sat_idle", b_data_out, 0);
    check("sat_hold", b_match_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
